// File: rtl/bellek_pkg.sv
// Shared types for the memory stage: uop layout, memory op codes, FSM states.
// Helpers classify loads and stores so the stage logic stays compact.
package bellek_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    LB,
    LH,
    LW,
    LBU,
    LHU,
    SB,
    SH,
    SW
  } bellek_e;

  typedef struct packed {
    logic        gecerli;
    bellek_e     bellek;
    logic [4:0]  hedef;
    logic [31:0] rd;
    logic [31:0] rs2;
  } uop_t;

  localparam int UOP_BIT = $bits(uop_t);

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] YANIT = 2'd1;
  localparam logic [1:0] TUT   = 2'd2;
  localparam logic [1:0] ATLA  = 2'd3;

  function automatic logic yukleme_mi(bellek_e b);
    return b inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic saklama_mi(bellek_e b);
    return b inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/bellek_hizala.sv
// Byte-lane logic: store data replication and byte enables,
// load word extraction with sign/zero extension, alignment check.
module bellek_hizala
  import bellek_pkg::*;
(
  input  logic [3:0]  islem,
  input  logic [1:0]  ofset,
  input  logic [31:0] kaynak,
  input  logic [31:0] yanit,
  output logic [31:0] veri,
  output logic [3:0]  maske,
  output logic [31:0] sonuc,
  output logic        hizali
);

  logic [31:0] w;

  assign w = yanit >> {ofset, 3'b000};

  always_comb begin
    veri   = kaynak;
    maske  = '0;
    sonuc  = w;
    hizali = 1'b1;
    case (bellek_e'(islem))
      SB: begin
        veri  = {4{kaynak[7:0]}};
        maske = 4'b0001 << ofset;
      end
      SH: begin
        veri   = {2{kaynak[15:0]}};
        maske  = 4'b0011 << ofset;
        hizali = !ofset[0];
      end
      SW: begin
        maske  = 4'b1111;
        hizali = (ofset == 2'b00);
      end
      LB:  sonuc = {{24{w[7]}}, w[7:0]};
      LH: begin
        sonuc  = {{16{w[15]}}, w[15:0]};
        hizali = !ofset[0];
      end
      LW:  hizali = (ofset == 2'b00);
      LBU: sonuc = {24'b0, w[7:0]};
      LHU: begin
        sonuc  = {16'b0, w[15:0]};
        hizali = !ofset[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bellek.sv
// Memory stage: issues loads/stores over valid/ready, waits for the
// load response, and registers the finished uop toward writeback.
module bellek
  import bellek_pkg::*;
#(
  parameter int VERI_BIT  = 32,
  parameter int ADRES_BIT = 32,
  parameter int MASKE_BIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cek_bosalt_i,
  input  logic                 cek_duraklat_i,
  output logic                 duraklat_o,
  input  logic [UOP_BIT-1:0]   bellek_uop_i,
  output logic [UOP_BIT-1:0]   geri_yaz_uop_o,
  output logic                 istek_gecerli_o,
  input  logic                 istek_hazir_i,
  output logic [ADRES_BIT-1:0] istek_adres_o,
  output logic                 istek_yaz_o,
  output logic [VERI_BIT-1:0]  istek_veri_o,
  output logic [MASKE_BIT-1:0] istek_maske_o,
  input  logic                 yanit_gecerli_i,
  input  logic [VERI_BIT-1:0]  yanit_veri_i,
  output logic                 hizasiz_o,
  output logic [ADRES_BIT-1:0] hizasiz_adres_o
);

  uop_t        giris, cikis_q, cikis_d;
  uop_t        tampon_q, tampon_d;
  uop_t        yuklu, sakli;
  logic [1:0]  durum_q, durum_d;
  logic        yukle, sakla, aday, hizali, hs, hizasiz_d;
  logic [31:0] h_veri, h_sonuc;
  logic [3:0]  h_maske;

  assign giris = uop_t'(bellek_uop_i);
  assign yukle = giris.gecerli && yukleme_mi(giris.bellek);
  assign sakla = giris.gecerli && saklama_mi(giris.bellek);

  bellek_hizala u_hizala (
    .islem  (giris.bellek),
    .ofset  (giris.rd[1:0]),
    .kaynak (giris.rs2),
    .yanit  (yanit_veri_i),
    .veri   (h_veri),
    .maske  (h_maske),
    .sonuc  (h_sonuc),
    .hizali (hizali)
  );

  assign aday = (durum_q == BOSTA) && (yukle || sakla)
             && !cek_duraklat_i && !cek_bosalt_i;
  assign istek_gecerli_o = aday && hizali;
  assign hs = istek_gecerli_o && istek_hazir_i;

  // Request fields are zero whenever no request is offered.
  assign istek_adres_o = istek_gecerli_o
    ? {giris.rd[ADRES_BIT-1:2], 2'b00} : '0;
  assign istek_yaz_o   = istek_gecerli_o && sakla;
  assign istek_veri_o  = istek_gecerli_o ? h_veri : '0;
  assign istek_maske_o = istek_gecerli_o ? h_maske : '0;

  always_comb begin
    yuklu    = giris;
    yuklu.rd = h_sonuc;
    sakli    = giris;
    sakli.rd = '0;
  end

  always_comb begin
    durum_d    = durum_q;
    cikis_d    = '0;
    tampon_d   = tampon_q;
    duraklat_o = 1'b0;
    hizasiz_d  = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (cek_bosalt_i || !giris.gecerli) begin
          cikis_d = '0;
        end else if (!(yukle || sakla)) begin
          cikis_d = giris;
        end else if (!hizali) begin
          hizasiz_d = !cek_duraklat_i;
        end else if (!cek_duraklat_i) begin
          duraklat_o = !(hs && sakla);
          if (hs && sakla) cikis_d = sakli;
          if (hs && yukle) durum_d = YANIT;
        end
      end
      YANIT: begin
        if (cek_bosalt_i) begin
          duraklat_o = 1'b1;
          durum_d    = yanit_gecerli_i ? BOSTA : ATLA;
        end else if (!yanit_gecerli_i) begin
          duraklat_o = 1'b1;
        end else if (!cek_duraklat_i) begin
          cikis_d = yuklu;
          durum_d = BOSTA;
        end else begin
          duraklat_o = 1'b1;
          tampon_d   = yuklu;
          durum_d    = TUT;
        end
      end
      TUT: begin
        if (cek_bosalt_i) begin
          durum_d = BOSTA;
        end else if (!cek_duraklat_i) begin
          cikis_d = tampon_q;
          durum_d = BOSTA;
        end else begin
          duraklat_o = 1'b1;
        end
      end
      default: begin
        // Hold upstream until the flushed load's response drains.
        duraklat_o = 1'b1;
        if (yanit_gecerli_i) durum_d = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q         <= BOSTA;
      cikis_q         <= '0;
      tampon_q        <= '0;
      hizasiz_o       <= 1'b0;
      hizasiz_adres_o <= '0;
    end else begin
      durum_q   <= durum_d;
      tampon_q  <= tampon_d;
      hizasiz_o <= hizasiz_d;
      if (!cek_duraklat_i) cikis_q <= cikis_d;
      if (hizasiz_d) hizasiz_adres_o <= giris.rd[ADRES_BIT-1:0];
    end
  end

  assign geri_yaz_uop_o = cikis_q;

endmodule

// File: tb/tb_bellek.sv
// Self-checking bench for the memory stage: directed scenarios
// followed by random single transactions against a byte-level model.
module tb_bellek;
  import bellek_pkg::*;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               cek_bosalt_i, cek_duraklat_i, duraklat_o;
  uop_t               uop_in;
  logic [UOP_BIT-1:0] wb_raw;
  uop_t               wb;
  logic               istek_gecerli_o, istek_hazir_i, istek_yaz_o;
  logic [31:0]        istek_adres_o, istek_veri_o;
  logic [3:0]         istek_maske_o;
  logic               yanit_gecerli_i;
  logic [31:0]        yanit_veri_i;
  logic               hizasiz_o;
  logic [31:0]        hizasiz_adres_o;

  int n_test = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign wb = uop_t'(wb_raw);

  bellek dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .cek_bosalt_i    (cek_bosalt_i),
    .cek_duraklat_i  (cek_duraklat_i),
    .duraklat_o      (duraklat_o),
    .bellek_uop_i    (uop_in),
    .geri_yaz_uop_o  (wb_raw),
    .istek_gecerli_o (istek_gecerli_o),
    .istek_hazir_i   (istek_hazir_i),
    .istek_adres_o   (istek_adres_o),
    .istek_yaz_o     (istek_yaz_o),
    .istek_veri_o    (istek_veri_o),
    .istek_maske_o   (istek_maske_o),
    .yanit_gecerli_i (yanit_gecerli_i),
    .yanit_veri_i    (yanit_veri_i),
    .hizasiz_o       (hizasiz_o),
    .hizasiz_adres_o (hizasiz_adres_o)
  );

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_test++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Access size in bytes from the opcode.
  function automatic int boyut(bellek_e op);
    if (op inside {LB, LBU, SB}) return 1;
    if (op inside {LH, LHU, SH}) return 2;
    return 4;
  endfunction

  function automatic logic hizali_m(bellek_e op, logic [31:0] ad);
    return (ad % boyut(op)) == 0;
  endfunction

  function automatic logic [31:0] sveri_m(bellek_e op, logic [31:0] rs);
    if (boyut(op) == 1) return (rs % 256) * 32'h0101_0101;
    if (boyut(op) == 2) return (rs % 65536) * 32'h0001_0001;
    return rs;
  endfunction

  function automatic logic [3:0] smaske_m(bellek_e op, logic [31:0] ad);
    int m;
    m = (1 << boyut(op)) - 1;
    return 4'(m << (ad % 4));
  endfunction

  function automatic logic [31:0] yukle_m(bellek_e op, logic [31:0] ad, logic [31:0] w);
    logic [31:0] s, b;
    s = w / (32'd1 << (8 * (ad % 4)));
    case (op)
      LB:  begin b = s % 256;   return (b >= 128)   ? b - 32'd256   : b; end
      LH:  begin b = s % 65536; return (b >= 32768) ? b - 32'd65536 : b; end
      LBU: return s % 256;
      LHU: return s % 65536;
      default: return s;
    endcase
  endfunction

  function automatic uop_t mk(bellek_e op, logic [31:0] ad, logic [31:0] rs);
    uop_t u;
    u.gecerli = 1'b1;
    u.bellek  = op;
    u.hedef   = 5'($urandom);
    u.rd      = ad;
    u.rs2     = rs;
    return u;
  endfunction

  // One transaction from presentation to writeback; all waits bounded by hz/ry.
  task automatic run_txn(input bellek_e op, input logic [31:0] ad, input logic [31:0] rs,
                         input int hz, input int ry, input logic [31:0] w);
    uop_t u, e;
    logic st;
    u  = mk(op, ad, rs);
    st = op inside {SB, SH, SW};
    @(negedge clk);
    uop_in = u;
    istek_hazir_i = 1'b0;
    yanit_gecerli_i = 1'b0;
    if (op == NOP) begin
      #1;
      chk("nop_req", istek_gecerli_o, 1'b0);
      chk("nop_stall", duraklat_o, 1'b0);
      @(negedge clk);
      chk("nop_out", wb_raw, u);
    end else if (!hizali_m(op, ad)) begin
      #1;
      chk("mis_req", istek_gecerli_o, 1'b0);
      chk("mis_stall", duraklat_o, 1'b0);
      @(negedge clk);
      uop_in = '0;
      chk("mis_pulse", hizasiz_o, 1'b1);
      chk("mis_addr", hizasiz_adres_o, ad);
      chk("mis_out_v", wb.gecerli, 1'b0);
    end else begin
      for (int i = 0; i <= hz; i++) begin
        if (i > 0) @(negedge clk);
        istek_hazir_i = (i == hz);
        #1;
        chk("req_v", istek_gecerli_o, 1'b1);
        chk("req_addr", istek_adres_o, ad & ~32'd3);
        chk("req_we", istek_yaz_o, st);
        chk("req_mask", istek_maske_o, st ? smaske_m(op, ad) : 4'd0);
        if (st) chk("req_data", istek_veri_o, sveri_m(op, rs));
        chk("req_stall", duraklat_o, !(i == hz && st));
      end
      if (st) begin
        @(negedge clk);
        istek_hazir_i = 1'b0;
        uop_in = '0;
        e = u;
        e.rd = '0;
        chk("st_out", wb_raw, e);
      end else begin
        for (int i = 1; i <= ry; i++) begin
          @(negedge clk);
          istek_hazir_i = 1'b0;
          yanit_gecerli_i = (i == ry);
          yanit_veri_i = w;
          #1;
          chk("ld_req_off", istek_gecerli_o, 1'b0);
          chk("ld_stall", duraklat_o, i != ry);
          chk("ld_bubble", wb.gecerli, 1'b0);
        end
        @(negedge clk);
        yanit_gecerli_i = 1'b0;
        uop_in = '0;
        e = u;
        e.rd = yukle_m(op, ad, w);
        chk("ld_out", wb_raw, e);
      end
    end
    uop_in = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    uop_t u, n, e;
    rst_i = 1'b1;
    cek_bosalt_i = 1'b0;
    cek_duraklat_i = 1'b0;
    uop_in = '0;
    istek_hazir_i = 1'b0;
    yanit_gecerli_i = 1'b0;
    yanit_veri_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", wb_raw, '0);
    chk("rst_req", istek_gecerli_o, 1'b0);
    chk("rst_stall", duraklat_o, 1'b0);
    chk("rst_mis", {hizasiz_o, hizasiz_adres_o}, '0);
    rst_i = 1'b0;

    // 1: aligned word store
    run_txn(SW, 32'h100, 32'hDEAD_BEEF, 0, 1, 32'h0);
    // 2: byte load, sign-extended, response on the fourth cycle
    run_txn(LB, 32'h103, 32'h0, 0, 4, 32'h80FF_FFFF);

    // 3: response arrives under downstream stall, buffered, then released
    u = mk(LHU, 32'h102, 32'h0);
    @(negedge clk);
    uop_in = u;
    istek_hazir_i = 1'b1;
    #1 chk("t3_req", istek_gecerli_o, 1'b1);
    @(negedge clk);
    istek_hazir_i = 1'b0;
    cek_duraklat_i = 1'b1;
    yanit_gecerli_i = 1'b1;
    yanit_veri_i = 32'hBEEF_1234;
    #1 chk("t3_stall_a", duraklat_o, 1'b1);
    @(negedge clk);
    yanit_gecerli_i = 1'b0;
    yanit_veri_i = '0;
    #1 chk("t3_stall_b", duraklat_o, 1'b1);
    chk("t3_held", wb.gecerli, 1'b0);
    @(negedge clk);
    cek_duraklat_i = 1'b0;
    #1 chk("t3_release", duraklat_o, 1'b0);
    @(negedge clk);
    uop_in = '0;
    e = u;
    e.rd = 32'h0000_BEEF;
    chk("t3_out", wb_raw, e);

    // 4: misaligned word load, pulse lasts one cycle, address held
    run_txn(LW, 32'h101, 32'h0, 0, 1, 32'h0);
    @(negedge clk);
    chk("t4_pulse_end", hizasiz_o, 1'b0);
    chk("t4_addr_hold", hizasiz_adres_o, 32'h101);

    // 5: flush while the load is outstanding
    u = mk(LW, 32'h200, 32'h0);
    n = mk(NOP, 32'h55, 32'h66);
    @(negedge clk);
    uop_in = u;
    istek_hazir_i = 1'b1;
    #1 chk("t5_req", istek_gecerli_o, 1'b1);
    @(negedge clk);
    istek_hazir_i = 1'b0;
    cek_bosalt_i = 1'b1;
    #1 chk("t5_no_req", istek_gecerli_o, 1'b0);
    @(negedge clk);
    cek_bosalt_i = 1'b0;
    uop_in = n;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t5_drain_stall", duraklat_o, 1'b1);
      chk("t5_drain_out", wb.gecerli, 1'b0);
      @(negedge clk);
    end
    yanit_gecerli_i = 1'b1;
    yanit_veri_i = 32'h1234_5678;
    #1 chk("t5_resp_stall", duraklat_o, 1'b1);
    @(negedge clk);
    yanit_gecerli_i = 1'b0;
    chk("t5_discard", wb.gecerli, 1'b0);
    #1 chk("t5_next_go", duraklat_o, 1'b0);
    @(negedge clk);
    uop_in = '0;
    chk("t5_next_out", wb_raw, n);

    // 6: reset while the load is outstanding, late response ignored
    u = mk(LW, 32'h300, 32'h0);
    @(negedge clk);
    uop_in = u;
    istek_hazir_i = 1'b1;
    @(negedge clk);
    istek_hazir_i = 1'b0;
    uop_in = '0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    yanit_gecerli_i = 1'b1;
    yanit_veri_i = 32'hCAFE_F00D;
    #1 chk("t6_stall", duraklat_o, 1'b0);
    chk("t6_req", istek_gecerli_o, 1'b0);
    @(negedge clk);
    yanit_gecerli_i = 1'b0;
    chk("t6_out", wb_raw, '0);
    chk("t6_mis", {hizasiz_o, hizasiz_adres_o}, '0);

    // Random single transactions
    for (int k = 0; k < 60; k++) begin
      run_txn(bellek_e'($urandom_range(0, 8)), $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(1, 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
